multi_clock_divider: RTL and testbench

- Parametrised successor to the single fixed clock divider. CHANNELS independent dividers share one input clock.
- Each channel has a runtime-programmable half-period and produces a 50% square wave plus a one-cycle rising-edge tick (for use as a clock enable).
- New divisors are written through a simple write port and applied glitch-free at the next half-period boundary.
- Sits between the board oscillator and the display, debounce and timer logic that need several slow rates.

---
 rtl/clkdiv_pkg.sv | 9 +
 rtl/multi_clock_divider_if.sv | 16 +
 rtl/clkdiv_channel.sv | 49 ++++
 rtl/multi_clock_divider.sv | 49 ++++
 tb/tb_multi_clock_divider.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and channel-index width helper for multi_clock_divider.
package clkdiv_pkg;
  localparam int unsigned DEFAULT_HALF_1HZ = 50_000_000;
  localparam int unsigned HALF_1KHZ_SCAN = 50_000;
  localparam int unsigned HALF_VGA_25MHZ = 2;
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_clock_divider_if.sv
// multi_clock_divider_if: divisor write port and per-channel divided outputs.
interface multi_clock_divider_if import clkdiv_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 26
);
  localparam int CH_W = ch_width(CHANNELS);
  logic wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [WIDTH-1:0] wr_half;
  logic wr_ack;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  modport master (output wr_en, wr_ch, wr_half, input wr_ack, pend, clk_out, tick);
  modport slave (input wr_en, wr_ch, wr_half, output wr_ack, pend, clk_out, tick);
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one half-period counter with shadowed divisor, square-wave output and rise tick.
module clkdiv_channel #(
  parameter int WIDTH = 26,
  parameter logic [WIDTH-1:0] DEFAULT_HALF = '0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic wr,
  input  logic restart,
  input  logic [WIDTH-1:0] wr_half,
  output logic pend,
  output logic clk_out,
  output logic tick
);
  logic [WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
  logic boundary, apply, kill;
  always_comb begin
    boundary = act_q != '0 && cnt_q == act_q - 1'b1;
    apply = pend_q && (restart || boundary || act_q == '0);
    kill = apply && shd_q == '0;
    shd_d = wr ? wr_half : shd_q;
    pend_d = wr || (pend_q && !apply);
    act_d = apply ? shd_q : act_q;
    cnt_d = (restart || act_q == '0 || boundary) ? '0 : cnt_q + 1'b1;
    clk_d = (restart || act_q == '0 || kill) ? 1'b0 : boundary ? ~clk_q : clk_q;
    tick_d = !restart && boundary && !clk_q && !kill;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
      act_q <= DEFAULT_HALF;
      shd_q <= '0;
      pend_q <= 1'b0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      shd_q <= shd_d;
      pend_q <= pend_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
    end
  end
  assign pend = pend_q;
  assign clk_out = clk_q;
  assign tick = tick_q;
endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: CHANNELS programmable clock dividers sharing clk_in.
// SYNC_RESTART_EN adds sync_restart, which applies pending divisors and phase-aligns all channels.
module multi_clock_divider import clkdiv_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 26,
  parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(DEFAULT_HALF_1HZ)
) (
  input logic clk_in,
  input logic rst,
`ifdef SYNC_RESTART_EN
  input logic sync_restart,
`endif
  multi_clock_divider_if.slave bus
);
  localparam int CH_W = ch_width(CHANNELS);
  logic wr_ok, wr_ack_d, wr_ack_q, restart;
  logic [CHANNELS-1:0] pend, clk_out, tick;
`ifdef SYNC_RESTART_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif
  always_comb begin
    wr_ok = bus.wr_en && ({1'b0, bus.wr_ch} < (CH_W+1)'(CHANNELS));
    wr_ack_d = wr_ok;
  end
  always_ff @(posedge clk_in) begin
    wr_ack_q <= rst ? 1'b0 : wr_ack_d;
  end
  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      clkdiv_channel #(.WIDTH(WIDTH), .DEFAULT_HALF(DEFAULT_HALF)) u_ch (
        .clk_in(clk_in),
        .rst(rst),
        .wr(wr_ok && bus.wr_ch == CH_W'(i)),
        .restart(restart),
        .wr_half(bus.wr_half),
        .pend(pend[i]),
        .clk_out(clk_out[i]),
        .tick(tick[i])
      );
    end
  endgenerate
  assign bus.wr_ack = wr_ack_q;
  assign bus.pend = pend;
  assign bus.clk_out = clk_out;
  assign bus.tick = tick;
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: directed vectors for a 3-channel, 8-bit divider with reset half-period 3.
module tb_multi_clock_divider;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic sync_restart = 1'b0;
  int compared = 0;
  int mismatched = 0;
  multi_clock_divider_if #(.CHANNELS(3), .WIDTH(8)) bus ();
  multi_clock_divider #(.CHANNELS(3), .WIDTH(8), .DEFAULT_HALF(8'd3)) dut (
    .clk_in(clk_in),
    .rst(rst),
`ifdef SYNC_RESTART_EN
    .sync_restart(sync_restart),
`endif
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  typedef struct packed {
    logic we;
    logic [1:0] ch;
    logic [7:0] h;
    logic [2:0] clk;
    logic [2:0] tick;
    logic [2:0] pend;
    logic ack;
  } vec_t;
  vec_t vt [16];
  task automatic check(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask
  task automatic step(input logic we, input logic [1:0] ch, input logic [7:0] h, input logic sr);
    bus.wr_en = we;
    bus.wr_ch = ch;
    bus.wr_half = h;
    sync_restart = sr;
    @(posedge clk_in);
    #1;
    bus.wr_en = 1'b0;
    sync_restart = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 8'd0, 1'b0);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    idle(2);
    check("rst_clk", 0, bus.clk_out, 3'b000);
    check("rst_tick", 0, bus.tick, 3'b000);
    check("rst_pend", 0, bus.pend, 3'b000);
    check("rst_ack", 0, bus.wr_ack, 1'b0);
    rst = 1'b0;
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_ch = '0;
    bus.wr_half = '0;
    vt[0]  = '{1'b1, 2'd1, 8'd2, 3'b000, 3'b000, 3'b010, 1'b1};
    vt[1]  = '{1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b010, 1'b0};
    vt[2]  = '{1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000, 1'b0};
    vt[3]  = '{1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000, 1'b0};
    vt[4]  = '{1'b1, 2'd3, 8'd9, 3'b101, 3'b000, 3'b000, 1'b0};
    vt[5]  = '{1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[6]  = '{1'b0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b000, 1'b0};
    vt[7]  = '{1'b0, 2'd0, 8'd0, 3'b010, 3'b000, 3'b000, 1'b0};
    vt[8]  = '{1'b0, 2'd0, 8'd0, 3'b101, 3'b101, 3'b000, 1'b0};
    vt[9]  = '{1'b0, 2'd0, 8'd0, 3'b101, 3'b000, 3'b000, 1'b0};
    vt[10] = '{1'b0, 2'd0, 8'd0, 3'b111, 3'b010, 3'b000, 1'b0};
    vt[11] = '{1'b0, 2'd0, 8'd0, 3'b010, 3'b000, 3'b000, 1'b0};
    vt[12] = '{1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[13] = '{1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[14] = '{1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000, 1'b0};
    vt[15] = '{1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000, 1'b0};
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(vt[k].we, vt[k].ch, vt[k].h, 1'b0);
      check("vec_clk", k + 1, bus.clk_out, vt[k].clk);
      check("vec_tick", k + 1, bus.tick, vt[k].tick);
      check("vec_pend", k + 1, bus.pend, vt[k].pend);
      check("vec_ack", k + 1, bus.wr_ack, vt[k].ack);
    end
    // Disable ch2 during its low phase, then re-enable at H = 1.
    do_reset();
    step(1'b1, 2'd2, 8'd0, 1'b0);
    check("dis_pend", 1, bus.pend, 3'b100);
    idle(2);
    check("dis_clk", 3, bus.clk_out, 3'b011);
    check("dis_tick", 3, bus.tick, 3'b011);
    check("dis_pend_clr", 3, bus.pend, 3'b000);
    idle(6);
    check("dis_hold", 9, bus.clk_out, 3'b011);
    step(1'b1, 2'd2, 8'd1, 1'b0);
    check("en_pend", 10, bus.pend, 3'b100);
    idle(1);
    check("en_pend_clr", 11, bus.pend, 3'b000);
    check("en_clk_lo", 11, bus.clk_out[2], 1'b0);
    idle(1);
    check("en_clk_hi", 12, bus.clk_out[2], 1'b1);
    check("en_tick", 12, bus.tick[2], 1'b1);
    idle(1);
    check("en_clk_lo2", 13, bus.clk_out[2], 1'b0);
    idle(1);
    check("en_clk_hi2", 14, bus.clk_out[2], 1'b1);
    // Write on the boundary, then overwrite before the next one.
    do_reset();
    idle(2);
    step(1'b1, 2'd0, 8'd4, 1'b0);
    check("bnd_clk", 3, bus.clk_out[0], 1'b1);
    check("bnd_pend", 3, bus.pend, 3'b001);
    check("bnd_ack1", 3, bus.wr_ack, 1'b1);
    step(1'b1, 2'd0, 8'd7, 1'b0);
    check("bnd_ack2", 4, bus.wr_ack, 1'b1);
    idle(1);
    check("bnd_ack_off", 5, bus.wr_ack, 1'b0);
    check("bnd_pend_hold", 5, bus.pend, 3'b001);
    idle(1);
    check("bnd_apply_clk", 6, bus.clk_out[0], 1'b0);
    check("bnd_apply_pend", 6, bus.pend, 3'b000);
    idle(6);
    check("bnd_h7_lo", 12, bus.clk_out[0], 1'b0);
    idle(1);
    check("bnd_h7_hi", 13, bus.clk_out[0], 1'b1);
    check("bnd_h7_tick", 13, bus.tick[0], 1'b1);
    // Reset mid-period discards the pending write.
    do_reset();
    idle(4);
    step(1'b1, 2'd1, 8'd5, 1'b0);
    check("mid_pend", 5, bus.pend, 3'b010);
    rst = 1'b1;
    idle(1);
    check("mid_rst_clk", 6, bus.clk_out, 3'b000);
    check("mid_rst_tick", 6, bus.tick, 3'b000);
    check("mid_rst_pend", 6, bus.pend, 3'b000);
    check("mid_rst_ack", 6, bus.wr_ack, 1'b0);
    rst = 1'b0;
    idle(2);
    check("post_rst_lo", 2, bus.clk_out, 3'b000);
    idle(1);
    check("post_rst_clk", 3, bus.clk_out, 3'b111);
    check("post_rst_tick", 3, bus.tick, 3'b111);
`ifdef SYNC_RESTART_EN
    do_reset();
    step(1'b1, 2'd0, 8'd2, 1'b0);
    idle(5);
    step(1'b1, 2'd2, 8'd5, 1'b0);
    step(1'b0, 2'd0, 8'd0, 1'b1);
    check("sr_clk", 8, bus.clk_out, 3'b000);
    check("sr_tick", 8, bus.tick, 3'b000);
    check("sr_pend", 8, bus.pend, 3'b000);
    idle(1);
    check("sr_clk9", 9, bus.clk_out, 3'b000);
    idle(1);
    check("sr_clk10", 10, bus.clk_out, 3'b001);
    check("sr_tick10", 10, bus.tick, 3'b001);
    idle(1);
    check("sr_clk11", 11, bus.clk_out, 3'b011);
    check("sr_tick11", 11, bus.tick, 3'b010);
    idle(2);
    check("sr_ch2_clk", 13, bus.clk_out[2], 1'b1);
    check("sr_ch2_tick", 13, bus.tick[2], 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
